// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : MEM/WB pipeline register and writeback stage.
//
// Holds one retiring instruction from MEM. Non-loads commit the cycle after
// capture; loads wait for a one-cycle dmem_rvalid_i pulse, then the response
// word is aligned and sign/zero-extended and committed in that same cycle.
// The register-file write port is driven combinationally so the regfile (and
// the forwarding network) see the write on the commit cycle.
//
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter and the instret_o port.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), synchronous active-low reset
//   mem_valid_i/ready_o   MEM -> WB handshake
//   mem_rd_addr_i         destination register
//   mem_rd_we_i           instruction writes rd
//   mem_is_load_i         result comes from the dmem response
//   mem_funct3_i          load type
//   mem_addr_lo_i         load address bits [1:0]
//   mem_result_i          result for non-loads
//   dmem_rvalid_i         load data valid pulse
//   dmem_rdata_i          raw aligned word from data memory
//   rd_addr_o/data_o/we_o register-file write port
//   instret_o             retired-instruction count (WB_INSTRET_EN only)
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic                  mem_rd_we_i,
    input  logic                  mem_is_load_i,
    input  logic [2:0]            mem_funct3_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic [XLEN-1:0]       mem_result_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_we_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]           instret_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        WAIT_LD = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic                  commit;
    logic                  ready;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_data;

    // Handshake and commit decode.
    always_comb begin
        ready  = (state_q != WAIT_LD) || dmem_rvalid_i;
        commit = (state_q == FULL) || ((state_q == WAIT_LD) && dmem_rvalid_i);
    end

    // Load alignment and extension; misaligned halfwords ignore addr_lo[0].
    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_lo_q)
            2'd0: ld_byte = dmem_rdata_i[7:0];
            2'd1: ld_byte = dmem_rdata_i[15:8];
            2'd2: ld_byte = dmem_rdata_i[23:16];
            2'd3: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        ld_data = dmem_rdata_i;
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state and outputs.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        result_d  = result_q;

        mem_ready_o = ready;
        rd_addr_o   = rd_addr_q;
        rd_we_o     = commit && we_q && (rd_addr_q != '0);
        rd_data_o   = '0;

        if (commit) begin
            state_d = EMPTY;
        end
        // A new capture overrides the drain to EMPTY: this is what lets a
        // load commit and the next instruction enter in the same cycle.
        if (mem_valid_i && ready) begin
            state_d   = mem_is_load_i ? WAIT_LD : FULL;
            rd_addr_d = mem_rd_addr_i;
            we_d      = mem_rd_we_i;
            funct3_d  = mem_funct3_i;
            addr_lo_d = mem_addr_lo_i;
            result_d  = mem_result_i;
        end

        case (state_q)
            FULL:    rd_data_o = result_q;
            WAIT_LD: rd_data_o = dmem_rvalid_i ? ld_data : '0;
            default: rd_data_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= EMPTY;
            rd_addr_q <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            result_q  <= result_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    // Counts every retirement, including x0 and non-writing instructions.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .mem_valid_i   (mem_valid),
        .mem_ready_o   (mem_ready),
        .mem_rd_addr_i (mem_rd_addr),
        .mem_rd_we_i   (mem_rd_we),
        .mem_is_load_i (mem_is_load),
        .mem_funct3_i  (mem_funct3),
        .mem_addr_lo_i (mem_addr_lo),
        .mem_result_i  (mem_result),
        .dmem_rvalid_i (dmem_rvalid),
        .dmem_rdata_i  (dmem_rdata),
        .rd_addr_o     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_we_o       (rd_we)
`ifdef WB_INSTRET_EN
        ,
        .instret_o     (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors   = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // At most one instruction is in flight; it retires when it is a
    // non-load, or when it is a load and the response arrives.
    logic        model_ok = 1'b0;
    logic        m_valid, m_load, m_we;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_alo;
    logic [31:0] m_res;
    logic [63:0] m_count;

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] alo,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        int unsigned half_off;
        b = 8'(w >> (8 * alo));
        half_off = (int'(alo) / 2) * 16;
        h = 16'(w >> half_off);
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic model_commit();
        return m_valid && (!m_load || dmem_rvalid);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_load = 1'b0; m_we = 1'b0; m_rd = '0;
            m_f3 = '0; m_alo = '0; m_res = '0; m_count = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            logic rdy;
            rdy = !(m_valid && m_load) || dmem_rvalid;
            if (model_commit()) begin
                m_count = m_count + 64'd1;
                m_valid = 1'b0;
            end
            if (mem_valid && rdy) begin
                m_valid = 1'b1; m_load = mem_is_load; m_we = mem_rd_we;
                m_rd = mem_rd_addr; m_f3 = mem_funct3; m_alo = mem_addr_lo;
                m_res = mem_result;
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (model_ok) begin
            logic        c;
            logic [31:0] ed;
            c  = model_commit();
            ed = !c ? 32'd0 : (m_load ? load_value(m_f3, m_alo, dmem_rdata) : m_res);
            chk("model_we",    64'(rd_we),     64'(c && m_we && (m_rd != 5'd0)));
            chk("model_addr",  64'(rd_addr),   64'(m_rd));
            chk("model_data",  64'(rd_data),   64'(ed));
            chk("model_ready", 64'(mem_ready), 64'(!(m_valid && m_load) || dmem_rvalid));
`ifdef WB_INSTRET_EN
            chk("model_instret", instret, m_count);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] res);
        mem_valid = 1'b1; mem_rd_addr = rd; mem_rd_we = we; mem_is_load = ld;
        mem_funct3 = f3; mem_addr_lo = alo; mem_result = res;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] w;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab[9];
    int pulses;

    initial begin
        ld_tab[0] = '{3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F};
        ld_tab[1] = '{3'b001, 2'd1, 32'h0000_8001, 32'hFFFF_8001};
        ld_tab[2] = '{3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001};
        ld_tab[3] = '{3'b010, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        ld_tab[4] = '{3'b100, 2'd1, 32'h0000_F000, 32'h0000_00F0};
        ld_tab[5] = '{3'b101, 2'd0, 32'h1234_FFFF, 32'h0000_FFFF};
        ld_tab[6] = '{3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        ld_tab[7] = '{3'b110, 2'd2, 32'h8765_4321, 32'h8765_4321};
        ld_tab[8] = '{3'b111, 2'd3, 32'hFFFF_0000, 32'hFFFF_0000};

        rst_n = 1'b0; mem_valid = 1'b0; mem_rd_addr = '0; mem_rd_we = 1'b0;
        mem_is_load = 1'b0; mem_funct3 = '0; mem_addr_lo = '0; mem_result = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        step(); step();
        @(negedge clk);
        chk("reset_we", 64'(rd_we), 64'd0);
        chk("reset_addr", 64'(rd_addr), 64'd0);
        chk("reset_data", 64'(rd_data), 64'd0);
        chk("reset_ready", 64'(mem_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // 1: single ALU op
        issue(5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234_5678);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t1_we", 64'(rd_we), 64'd1);
        chk("t1_addr", 64'(rd_addr), 64'd5);
        chk("t1_data", 64'(rd_data), 64'h1234_5678);
        step();
        @(negedge clk);
        chk("t1_we_after", 64'(rd_we), 64'd0);
        step();

        // 2: LB with a 3-cycle response
        issue(5'd4, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t2_ready_c1", 64'(mem_ready), 64'd0);
        step();
        @(negedge clk);
        chk("t2_ready_c2", 64'(mem_ready), 64'd0);
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("t2_ready_rv", 64'(mem_ready), 64'd1);
        chk("t2_we", 64'(rd_we), 64'd1);
        chk("t2_data", 64'(rd_data), 64'hFFFF_FF80);
        step();
        dmem_rvalid = 1'b0;

        // 3: LHU response coincides with the next ALU issue
        issue(5'd6, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0);
        step();
        mem_valid = 1'b0;
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0001;
        issue(5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_A5A5);
        @(negedge clk);
        chk("t3_ld_data", 64'(rd_data), 64'h0000_BEEF);
        chk("t3_ld_addr", 64'(rd_addr), 64'd6);
        chk("t3_ready", 64'(mem_ready), 64'd1);
        step();
        dmem_rvalid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        chk("t3_alu_we", 64'(rd_we), 64'd1);
        chk("t3_alu_addr", 64'(rd_addr), 64'd7);
        chk("t3_alu_data", 64'(rd_data), 64'h0000_A5A5);
        step();

        // 4: write to x0 retires without a write; then a spurious response
        issue(5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h55);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t4_we_x0", 64'(rd_we), 64'd0);
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("spur_we", 64'(rd_we), 64'd0);
        chk("spur_data", 64'(rd_data), 64'd0);
`ifdef WB_INSTRET_EN
        chk("t4_instret", instret, 64'd5);
`endif
        step();
        dmem_rvalid = 1'b0;

        // 5: reset while waiting for a load
        issue(5'd3, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
        step();
        mem_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("t5_we", 64'(rd_we), 64'd0);
        chk("t5_ready", 64'(mem_ready), 64'd1);
        chk("t5_data", 64'(rd_data), 64'd0);
`ifdef WB_INSTRET_EN
        chk("t5_instret", instret, 64'd0);
`endif
        step();
        dmem_rvalid = 1'b0;

        // 6: 100 back-to-back ALU ops
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            issue(5'((i % 31) + 1), 1'b1, 1'b0, 3'b000, 2'd0, 32'(i * 32'h0101_0101));
            @(negedge clk);
            chk("t6_ready", 64'(mem_ready), 64'd1);
            if (i > 0 && rd_we) pulses++;
            step();
        end
        mem_valid = 1'b0;
        @(negedge clk);
        if (rd_we) pulses++;
        chk("t6_last_data", 64'(rd_data), 64'(32'(99 * 32'h0101_0101)));
        step();
        chk("t6_pulses", 64'(pulses), 64'd100);
`ifdef WB_INSTRET_EN
        @(negedge clk);
        chk("t6_instret", instret, 64'd100);
`endif
        step();

        // Load extraction table, minimum latency
        foreach (ld_tab[k]) begin
            issue(5'd9, 1'b1, 1'b1, ld_tab[k].f3, ld_tab[k].alo, 32'h0);
            step();
            mem_valid = 1'b0;
            dmem_rvalid = 1'b1; dmem_rdata = ld_tab[k].w;
            @(negedge clk);
            chk("ld_tab_data", 64'(rd_data), 64'(ld_tab[k].exp));
            step();
            dmem_rvalid = 1'b0;
        end

        // Non-writing instruction still flows through
        issue(5'd12, 1'b0, 1'b0, 3'b000, 2'd0, 32'h7777_7777);
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("nowe_we", 64'(rd_we), 64'd0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
